vector_component_packer: RTL and testbench



---
 rtl/vector_component_packer.sv | 199 +++++++++++++++++++
 tb/tb_vector_component_packer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vector_component_packer.sv
// -----------------------------------------------------------------------------
// vector_component_packer
//
// Packs four 16-bit components into one 64-bit vector register value
// {c3, c2, c1, c0} for the vector register file write port. The inverse of
// the vector component extractor.
//
// Optional feature, macro VCP_SCREEN_TO_WORLD_EN:
//   c3 (x) and c2 (y) are taken as screen-space pixel coordinates and are
//   converted back to world-space sign-magnitude 8.7 fixed point:
//     x: d = 2*px - 640             (px saturated to 640)
//     y: e = 640 - floor(16*py / 5) (py saturated to 400)
//   The divide uses a 13-cycle restoring shift-subtract divider, so a result
//   appears 14 cycles after the accepting edge. Without the macro every
//   component passes through untouched and the latency is 1 cycle.
//
// Ports:
//   clock           sole clock, rising edge
//   reset           synchronous, active-high reset
//   in_valid        input components present
//   in_ready        block can accept (high only in IDLE)
//   in_component0   packed to [15:0]
//   in_component1   packed to [31:16]
//   in_component2   y component, packed to [47:32]
//   in_component3   x component, packed to [63:48]
//   out_valid       out_vector_val holds a result
//   out_ready       consumer takes the result (only looked at in HOLD)
//   out_vector_val  {c3, c2, c1, c0}
// -----------------------------------------------------------------------------
module vector_component_packer (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_component0,
    input  logic [15:0] in_component1,
    input  logic [15:0] in_component2,
    input  logic [15:0] in_component3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_vector_val
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_out_valid;
    logic [63:0] r_out;

    assign in_ready       = (r_state == IDLE);
    assign out_valid      = r_out_valid;
    assign out_vector_val = r_out;

`ifdef VCP_SCREEN_TO_WORLD_EN

    localparam logic [9:0]  PX_MAX       = 10'd640;
    localparam logic [8:0]  PY_MAX       = 9'd400;
    localparam logic [3:0]  DIVISOR      = 4'd5;
    localparam logic [3:0]  LAST_DIV_CNT = 4'd12;
    localparam logic signed [13:0] WORLD_HALF = 14'sd640;

    // Pixel coordinates clamp to the screen edge; the sign bit is ignored.
    function automatic logic [9:0] sat_px(input logic [14:0] v);
        return (v > 15'(PX_MAX)) ? PX_MAX : v[9:0];
    endfunction

    function automatic logic [8:0] sat_py(input logic [14:0] v);
        return (v > 15'(PY_MAX)) ? PY_MAX : v[8:0];
    endfunction

    // Two's complement to sign-magnitude; zero always encodes as 0x0000.
    function automatic logic [15:0] sm_encode(input logic signed [13:0] d);
        logic [13:0] mag;
        mag = d[13] ? 14'(-d) : d;
        return {d[13], 1'b0, mag};
    endfunction

    logic [15:0] r_c0;
    logic [15:0] r_c1;
    logic [15:0] r_x;
    logic [12:0] r_dvd;
    logic [2:0]  r_rem;
    logic [12:0] r_quo;
    logic [3:0]  r_cnt;

    logic [9:0]         w_px;
    logic [8:0]         w_py;
    logic signed [13:0] w_x_d;
    logic [3:0]         w_rem_sh;
    logic               w_ge;
    logic [2:0]         w_rem_nxt;
    logic [12:0]        w_quo_nxt;
    logic signed [13:0] w_y_e;
    logic               w_unused_sign;

    assign w_unused_sign = in_component3[15] ^ in_component2[15];

    assign w_px  = sat_px(in_component3[14:0]);
    assign w_py  = sat_py(in_component2[14:0]);
    assign w_x_d = $signed({3'b000, w_px, 1'b0}) - WORLD_HALF;

    // One restoring step: bring down the next dividend bit, subtract 5 if it fits.
    assign w_rem_sh  = {r_rem, r_dvd[12]};
    assign w_ge      = (w_rem_sh >= DIVISOR);
    assign w_rem_nxt = w_ge ? 3'(w_rem_sh - DIVISOR) : w_rem_sh[2:0];
    assign w_quo_nxt = {r_quo[11:0], w_ge};

    // Quotient is at most 1280, so 640 - q stays within -640..640.
    assign w_y_e = WORLD_HALF - $signed({1'b0, w_quo_nxt});

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_out       <= 64'h0;
            r_c0        <= 16'h0;
            r_c1        <= 16'h0;
            r_x         <= 16'h0;
            r_dvd       <= 13'h0;
            r_rem       <= 3'h0;
            r_quo       <= 13'h0;
            r_cnt       <= 4'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_c0    <= in_component0;
                        r_c1    <= in_component1;
                        r_x     <= sm_encode(w_x_d);
                        r_dvd   <= {w_py, 4'b0000};
                        r_rem   <= 3'h0;
                        r_quo   <= 13'h0;
                        r_cnt   <= 4'h0;
                        r_state <= DIV;
                    end
                end
                DIV: begin
                    r_dvd <= {r_dvd[11:0], 1'b0};
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + 4'd1;
                    // Final quotient bit is resolved this cycle; pack straight from it.
                    if (r_cnt == LAST_DIV_CNT) begin
                        r_out       <= {r_x, sm_encode(w_y_e), r_c1, r_c0};
                        r_out_valid <= 1'b1;
                        r_state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`else

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_out       <= 64'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_out       <= {in_component3, in_component2,
                                        in_component1, in_component0};
                        r_out_valid <= 1'b1;
                        r_state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                // DIV has no role in the pass-through build.
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_vector_component_packer.sv
// -----------------------------------------------------------------------------
// tb_vector_component_packer
//
// Directed bench for vector_component_packer. Works for both builds; when
// VCP_SCREEN_TO_WORLD_EN is defined the expected vectors include the
// hand-computed screen-to-world conversion of c3/c2 and the 14-cycle latency.
// -----------------------------------------------------------------------------
module tb_vector_component_packer;

`ifdef VCP_SCREEN_TO_WORLD_EN
    localparam int LAT = 14;
`else
    localparam int LAT = 1;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_component0;
    logic [15:0] in_component1;
    logic [15:0] in_component2;
    logic [15:0] in_component3;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_vector_val;

    int n_checks = 0;
    int n_errors = 0;

    vector_component_packer dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_component0  (in_component0),
        .in_component1  (in_component1),
        .in_component2  (in_component2),
        .in_component3  (in_component3),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_vector_val (out_vector_val)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want summary before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h, want 0x%016h", tag, got, exp);
        end
    endtask

    task automatic junk_inputs();
        in_component0 = 16'($urandom);
        in_component1 = 16'($urandom);
        in_component2 = 16'($urandom);
        in_component3 = 16'($urandom);
    endtask

    // One transaction: wait for in_ready, accept, check exact latency, optionally
    // stall in HOLD for 'hold' cycles, then consume.
    task automatic run_txn(input string tag, input logic [63:0] vin, input logic [63:0] vexp,
                           input int hold, input bit busy, input bit keep_rdy);
        int guard;
        bit early;
        bit unstable;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clock); #1;
            guard++;
        end
        check_val({tag, "_in_ready_idle"}, {63'h0, in_ready}, 64'h1);
        {in_component3, in_component2, in_component1, in_component0} = vin;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        junk_inputs();
        early = 1'b0;
        for (int k = 0; k < LAT - 1; k++) begin
            if (out_valid) early = 1'b1;
            if (busy) begin
                in_valid = k[0];
                junk_inputs();
            end
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        check_val({tag, "_early_valid"}, {63'h0, early}, 64'h0);
        check_val({tag, "_out_valid"}, {63'h0, out_valid}, 64'h1);
        check_val({tag, "_vector"}, out_vector_val, vexp);
        check_val({tag, "_in_ready_busy"}, {63'h0, in_ready}, 64'h0);
        unstable = 1'b0;
        for (int h = 0; h < hold; h++) begin
            if (busy) begin
                in_valid = ~h[0];
                junk_inputs();
            end
            @(posedge clock); #1;
            if (!out_valid || out_vector_val !== vexp || in_ready) unstable = 1'b1;
        end
        in_valid = 1'b0;
        if (hold > 0) check_val({tag, "_hold_stable"}, {63'h0, unstable}, 64'h0);
        if (!keep_rdy) out_ready = 1'b1;
        @(posedge clock); #1;
        if (!keep_rdy) out_ready = 1'b0;
        check_val({tag, "_consumed_valid"}, {63'h0, out_valid}, 64'h0);
        check_val({tag, "_back_to_idle"}, {63'h0, in_ready}, 64'h1);
    endtask

`ifdef VCP_SCREEN_TO_WORLD_EN
    localparam int NV = 6;
    // {c3, c2, c1, c0} in, expected packed vector out.
    logic [63:0] vin_tab [NV] = '{
        64'h0000_0000_AAAA_5555,   // px 0, py 0
        64'h0140_00C8_1111_2222,   // px 320, py 200
        64'h0280_0190_3333_4444,   // px 640, py 400
        64'h7FFF_0001_FFFF_0000,   // px saturates, py 1 -> q 3
        64'h8140_8190_0001_0002,   // sign bits ignored: 320, 400
        64'h0001_0007_BEEF_CAFE    // px 1 -> -638, py 7 -> q 22 -> 618
    };
    logic [63:0] vexp_tab [NV] = '{
        64'h8280_0280_AAAA_5555,
        64'h0000_0000_1111_2222,
        64'h0280_8280_3333_4444,
        64'h0280_027D_FFFF_0000,
        64'h0000_8280_0001_0002,
        64'h827E_026A_BEEF_CAFE
    };
`else
    localparam int NV = 5;
    logic [63:0] vin_tab [NV] = '{
        64'h1234_5678_9ABC_DEF0,
        64'hFFFF_0000_FFFF_0000,
        64'h8000_0001_0002_7FFF,
        64'h0000_0000_0000_0000,
        64'hA5A5_5A5A_C3C3_3C3C
    };
    logic [63:0] vexp_tab [NV] = '{
        64'h1234_5678_9ABC_DEF0,
        64'hFFFF_0000_FFFF_0000,
        64'h8000_0001_0002_7FFF,
        64'h0000_0000_0000_0000,
        64'hA5A5_5A5A_C3C3_3C3C
    };
`endif

    initial begin
        bit seen;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        junk_inputs();
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        check_val("reset_in_ready", {63'h0, in_ready}, 64'h1);
        check_val("reset_out_valid", {63'h0, out_valid}, 64'h0);
        check_val("reset_vector", out_vector_val, 64'h0);

        // Backpressure on the first vector, busy-drop on the second.
        run_txn("v0_bp", vin_tab[0], vexp_tab[0], 5, 1'b0, 1'b0);
        run_txn("v1_busy", vin_tab[1], vexp_tab[1], 3, 1'b1, 1'b0);
        for (int i = 2; i < NV; i++) begin
            run_txn($sformatf("v%0d", i), vin_tab[i], vexp_tab[i], 0, 1'b0, 1'b0);
        end

        // out_ready tied high: HOLD lasts exactly one cycle.
        out_ready = 1'b1;
        run_txn("rdy_high", vin_tab[0], vexp_tab[0], 0, 1'b0, 1'b1);
        out_ready = 1'b0;

        // Reset in the middle of a transaction discards it.
        {in_component3, in_component2, in_component1, in_component0} = vin_tab[2];
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        check_val("midreset_out_valid", {63'h0, out_valid}, 64'h0);
        check_val("midreset_vector", out_vector_val, 64'h0);
        check_val("midreset_in_ready", {63'h0, in_ready}, 64'h1);
        @(posedge clock); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < LAT + 10; k++) begin
            @(posedge clock); #1;
            if (out_valid) seen = 1'b1;
        end
        out_ready = 1'b0;
        check_val("midreset_no_result", {63'h0, seen}, 64'h0);

        run_txn("recover", vin_tab[NV-1], vexp_tab[NV-1], 2, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
